// File: rtl/nes_bus_pkg.sv
// Package for the CPU-bus memory responder.
// Contents:
//   bus_state_t       responder FSM states
//   NES_VEC_RESET_LO  low byte address of the 6502 reset vector
//   NES_VEC_RESET_HI  high byte address of the 6502 reset vector
//   OPEN_BUS_RESET    value of the open-bus latch after reset
package nes_bus_pkg;
  typedef enum logic [1:0] {BUS_IDLE, BUS_WAIT, BUS_RESP} bus_state_t;

  localparam logic [15:0] NES_VEC_RESET_LO = 16'hFFFC;
  localparam logic [15:0] NES_VEC_RESET_HI = 16'hFFFD;
  localparam logic [7:0]  OPEN_BUS_RESET   = 8'h00;
endpackage

// File: rtl/nes_bus_ram_array.sv
// Single-port storage for the bus responder.
// Writes happen on the clock edge; reads are asynchronous.
// Contents are never cleared, including on reset.
// Ports:
//   clock    in  system clock
//   i_we     in  write enable
//   i_addr   in  word index (DEPTH_LOG2 bits)
//   i_wdata  in  write data
//   o_rdata  out read data at i_addr
module nes_bus_ram_array
  import nes_bus_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clock,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);
  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/nes_bus_memory.sv
// CPU-bus memory responder. It provides a RAM window that mirrors across its
// decoded range and adds optional wait states. Reads outside the window return
// the last byte that was driven on the bus (open-bus emulation).
// Optional feature macro: NES_BUS_RESET_VECTOR_EN. When defined, reads of
// 0xFFFC/0xFFFD return RESET_VEC. This override requires ADDR_W=16.
// Ports:
//   clock, reset             system clock; synchronous active-high reset
//   req_valid/req_ready      request handshake; ready is high only when idle
//   req_addr/we/wdata        request payload; held stable until accepted
//   rsp_valid                one-cycle response strobe
//   rsp_rdata                read data, or the echoed write data
//   rsp_hit                  address decoded in the window or vector
module nes_bus_memory
  import nes_bus_pkg::*;
#(
  parameter int                 ADDR_W      = 16,
  parameter int                 DATA_W      = 8,
  parameter int                 DEPTH_LOG2  = 11,
  parameter int                 WINDOW_LOG2 = 13,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int                 WAIT_STATES = 0,
  parameter logic [15:0]        RESET_VEC   = 16'h8000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_hit
);
  bus_state_t          r_state, w_next;
  logic [3:0]          r_wait_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_open_bus;

  logic                w_accept;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_we;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_win_hit;
  logic                w_vec;
  logic [DATA_W-1:0]   w_vec_data;
  logic                w_hit;
  logic [DATA_W-1:0]   w_ram_rdata;
  logic [DATA_W-1:0]   w_rsp_data;
  logic                w_mem_we;

  assign req_ready = (r_state == BUS_IDLE);
  assign w_accept  = req_valid & req_ready;

  // When idle, the live request drives decode. This lets a zero-wait access
  // load its response on the accept edge. After that, the latched copy is used.
  assign w_addr  = (r_state == BUS_IDLE) ? req_addr  : r_addr;
  assign w_we    = (r_state == BUS_IDLE) ? req_we    : r_we;
  assign w_wdata = (r_state == BUS_IDLE) ? req_wdata : r_wdata;

  assign w_win_hit = (w_addr >> WINDOW_LOG2) == (BASE_ADDR >> WINDOW_LOG2);

`ifdef NES_BUS_RESET_VECTOR_EN
  logic w_vec_lo, w_vec_hi;
  assign w_vec_lo   = (w_addr == ADDR_W'(NES_VEC_RESET_LO));
  assign w_vec_hi   = (w_addr == ADDR_W'(NES_VEC_RESET_HI));
  assign w_vec      = w_vec_lo | w_vec_hi;
  assign w_vec_data = w_vec_lo ? DATA_W'(RESET_VEC[7:0]) : DATA_W'(RESET_VEC[15:8]);
`else
  logic w_unused_vec;
  assign w_vec        = 1'b0;
  assign w_vec_data   = '0;
  assign w_unused_vec = ^RESET_VEC;
`endif

  assign w_hit = w_vec | w_win_hit;

  always_comb begin
    w_rsp_data = r_open_bus;
    if (w_we)           w_rsp_data = w_wdata;
    else if (w_vec)     w_rsp_data = w_vec_data;
    else if (w_win_hit) w_rsp_data = w_ram_rdata;
  end

  // The write commits only at the edge that ends RESP. A reset sampled on
  // that same edge cancels it. Vector addresses never reach storage.
  assign w_mem_we = (r_state == BUS_RESP) & r_we & w_win_hit & ~w_vec & ~reset;

  nes_bus_ram_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_mem_we),
    .i_addr  (w_addr[DEPTH_LOG2-1:0]),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      BUS_IDLE: if (w_accept) w_next = (WAIT_STATES > 0) ? BUS_WAIT : BUS_RESP;
      BUS_WAIT: if (r_wait_cnt == 4'd0) w_next = BUS_RESP;
      BUS_RESP: w_next = BUS_IDLE;
      default:  w_next = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= BUS_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= 4'd0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_hit    <= 1'b0;
      r_open_bus <= DATA_W'(OPEN_BUS_RESET);
    end else begin
      if (w_accept) begin
        r_addr     <= req_addr;
        r_we       <= req_we;
        r_wdata    <= req_wdata;
        r_wait_cnt <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
      end else if (r_state == BUS_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      // Register the response on entry to RESP. rsp_valid is then high for
      // exactly the RESP cycle.
      rsp_valid <= (w_next == BUS_RESP);
      if (w_next == BUS_RESP) begin
        rsp_rdata <= w_rsp_data;
        rsp_hit   <= w_hit;
      end
      if (r_state == BUS_RESP) r_open_bus <= rsp_rdata;
    end
  end
endmodule

// File: tb/tb_nes_bus_memory.sv
module tb_nes_bus_memory;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [15:0] req_addr  [2];
  logic        req_we    [2];
  logic [7:0]  req_wdata [2];
  logic        rsp_valid [2];
  logic [7:0]  rsp_rdata [2];
  logic        rsp_hit   [2];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Instance 0: two wait states. Instance 1: zero wait states.
  nes_bus_memory #(.WAIT_STATES(2), .RESET_VEC(16'h8000)) u_dut_w2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_we(req_we[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_hit(rsp_hit[0]));

  nes_bus_memory #(.WAIT_STATES(0), .RESET_VEC(16'h8000)) u_dut_w0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_we(req_we[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_hit(rsp_hit[1]));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete access from idle. lat counts cycles from accept to rsp_valid.
  // -1 means no response arrived within the bound.
  task automatic access(input int s, input logic [15:0] a, input logic we,
                        input logic [7:0] wd, output logic [7:0] rd,
                        output logic hit, output int lat);
    req_addr[s] = a; req_we[s] = we; req_wdata[s] = wd; req_valid[s] = 1'b1;
    tick();
    req_valid[s] = 1'b0;
    lat = -1; rd = 8'hxx; hit = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid[s] === 1'b1) begin
        lat = k; rd = rsp_rdata[s]; hit = rsp_hit[s];
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_addr[s] = '0; req_we[s] = 1'b0; req_wdata[s] = '0;
    end
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    for (int s = 0; s < 2; s++) begin
      total++; if (rsp_valid[s] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", s, rsp_valid[s]); end
      total++; if (rsp_rdata[s] !== 8'h00) begin bad++; $display("FAIL reset_rdata[%0d]: got %h want 00", s, rsp_rdata[s]); end
      total++; if (rsp_hit[s] !== 1'b0) begin bad++; $display("FAIL reset_hit[%0d]: got %b want 0", s, rsp_hit[s]); end
      total++; if (req_ready[s] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 1", s, req_ready[s]); end
    end
  endtask

  task automatic test_mirror();
    logic [7:0] rd; logic hit; int lat;
    access(0, 16'h0005, 1'b1, 8'hA9, rd, hit, lat);
    total++; if (lat != 3) begin bad++; $display("FAIL mirror_wr_latency: got %0d want 3", lat); end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL mirror_wr_hit: got %b want 1", hit); end
    total++; if (rd !== 8'hA9) begin bad++; $display("FAIL mirror_wr_echo: got %h want a9", rd); end
    access(0, 16'h0805, 1'b0, 8'h00, rd, hit, lat);
    total++; if (rd !== 8'hA9) begin bad++; $display("FAIL mirror_rd_0805: got %h want a9", rd); end
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL mirror_rd_hit: got %b want 1", hit); end
  endtask

  task automatic test_open_bus();
    logic [7:0] rd; logic hit; int lat;
    access(0, 16'h2000, 1'b0, 8'h00, rd, hit, lat);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL openbus_hit: got %b want 0", hit); end
    total++; if (rd !== 8'hA9) begin bad++; $display("FAIL openbus_rd_2000: got %h want a9", rd); end
    access(0, 16'h0000, 1'b1, 8'h3C, rd, hit, lat);
    access(0, 16'h4000, 1'b1, 8'h11, rd, hit, lat);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL miss_wr_hit: got %b want 0", hit); end
    total++; if (rd !== 8'h11) begin bad++; $display("FAIL miss_wr_echo: got %h want 11", rd); end
    access(0, 16'h2001, 1'b0, 8'h00, rd, hit, lat);
    total++; if (rd !== 8'h11) begin bad++; $display("FAIL openbus_after_wr: got %h want 11", rd); end
    access(0, 16'h0000, 1'b0, 8'h00, rd, hit, lat);
    total++; if (rd !== 8'h3C) begin bad++; $display("FAIL miss_wr_no_store: got %h want 3c", rd); end
  endtask

  task automatic test_ready_hold();
    logic [7:0] rd; logic hit; int lat; int nvalid;
    access(0, 16'h0001, 1'b1, 8'h77, rd, hit, lat);
    req_addr[0] = 16'h0001; req_we[0] = 1'b0; req_valid[0] = 1'b1;
    nvalid = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++; if (req_ready[0] !== (k == 4 || k == 8))
        begin bad++; $display("FAIL hold_ready k=%0d: got %b want %b", k, req_ready[0], (k == 4 || k == 8)); end
      total++; if (rsp_valid[0] !== (k == 3 || k == 7))
        begin bad++; $display("FAIL hold_valid k=%0d: got %b want %b", k, rsp_valid[0], (k == 3 || k == 7)); end
      if (rsp_valid[0] === 1'b1) begin
        nvalid++;
        total++; if (rsp_rdata[0] !== 8'h77) begin bad++; $display("FAIL hold_rdata k=%0d: got %h want 77", k, rsp_rdata[0]); end
      end
    end
    req_valid[0] = 1'b0;
    total++; if (nvalid != 2) begin bad++; $display("FAIL hold_resp_count: got %0d want 2", nvalid); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] rd; logic hit; int lat;
    access(0, 16'h0010, 1'b1, 8'h22, rd, hit, lat);
    req_addr[0] = 16'h0010; req_we[0] = 1'b1; req_wdata[0] = 8'h55; req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    tick(); tick();
    total++; if (rsp_valid[0] !== 1'b1) begin bad++; $display("FAIL abort_in_resp: got %b want 1", rsp_valid[0]); end
    reset = 1'b1;
    tick();
    total++; if (rsp_valid[0] !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", rsp_valid[0]); end
    reset = 1'b0;
    tick();
    access(0, 16'h3000, 1'b0, 8'h00, rd, hit, lat);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL abort_openbus_cleared: got %h want 00", rd); end
    access(0, 16'h0010, 1'b0, 8'h00, rd, hit, lat);
    total++; if (rd !== 8'h22) begin bad++; $display("FAIL abort_no_commit: got %h want 22", rd); end
  endtask

  task automatic test_vector();
    logic [7:0] rd; logic hit; int lat;
    access(0, 16'h4000, 1'b1, 8'h5A, rd, hit, lat);
    access(0, 16'hFFFC, 1'b0, 8'h00, rd, hit, lat);
`ifdef NES_BUS_RESET_VECTOR_EN
    total++; if (rd !== 8'h00 || hit !== 1'b1) begin bad++; $display("FAIL vec_lo: got %h/%b want 00/1", rd, hit); end
    access(0, 16'hFFFD, 1'b0, 8'h00, rd, hit, lat);
    total++; if (rd !== 8'h80 || hit !== 1'b1) begin bad++; $display("FAIL vec_hi: got %h/%b want 80/1", rd, hit); end
`else
    total++; if (rd !== 8'h5A || hit !== 1'b0) begin bad++; $display("FAIL vec_lo_off: got %h/%b want 5a/0", rd, hit); end
    access(0, 16'hFFFD, 1'b0, 8'h00, rd, hit, lat);
    total++; if (rd !== 8'h5A || hit !== 1'b0) begin bad++; $display("FAIL vec_hi_off: got %h/%b want 5a/0", rd, hit); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic hit; int lat;
    access(1, 16'h0003, 1'b1, 8'h66, rd, hit, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL b2b_latency: got %0d want 1", lat); end
    req_addr[1] = 16'h0003; req_we[1] = 1'b0; req_valid[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++; if (rsp_valid[1] !== k[0])
        begin bad++; $display("FAIL b2b_valid k=%0d: got %b want %b", k, rsp_valid[1], k[0]); end
      total++; if (req_ready[1] !== !k[0])
        begin bad++; $display("FAIL b2b_ready k=%0d: got %b want %b", k, req_ready[1], !k[0]); end
      if (k[0]) begin
        total++; if (rsp_rdata[1] !== 8'h66) begin bad++; $display("FAIL b2b_rdata k=%0d: got %h want 66", k, rsp_rdata[1]); end
      end
    end
    req_valid[1] = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_mirror();
    test_open_bus();
    test_ready_hold();
    test_reset_abort();
    test_vector();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
